// File: rtl/reg_alu_sequencer_pkg.sv
// Shared opcodes, FSM states and register selectors for the
// register-file execute sequencer.
package reg_alu_sequencer_pkg;

   typedef enum logic [2:0] {
      OP_MOV = 3'b000,
      OP_ADD = 3'b001,
      OP_SUB = 3'b010,
      OP_AND = 3'b011,
      OP_OR  = 3'b100,
      OP_XOR = 3'b101,
      OP_NOT = 3'b110,
      OP_LDI = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD_A = 3'd1,
      ST_RD_B = 3'd2,
      ST_EXEC = 3'd3,
      ST_WB   = 3'd4
   } state_e;

   localparam logic [2:0] R0_SELECTOR = 3'd0;
   localparam logic [2:0] R1_SELECTOR = 3'd1;
   localparam logic [2:0] R2_SELECTOR = 3'd2;
   localparam logic [2:0] R3_SELECTOR = 3'd3;
   localparam logic [2:0] R4_SELECTOR = 3'd4;
   localparam logic [2:0] R5_SELECTOR = 3'd5;
   localparam logic [2:0] R6_SELECTOR = 3'd6;
   localparam logic [2:0] R7_SELECTOR = 3'd7;

endpackage

// File: rtl/reg_alu_sequencer_alu_core.sv
// Combinational two-operand ALU: result = a OP b, carry is the
// ADD carry-out or the SUB borrow, zero for every other op.
module alu_core
   import reg_alu_sequencer_pkg::*;
#(
   parameter int W = 8
) (
   input  op_e          op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] result,
   output logic         carry
);

   always_comb begin
      result = '0;
      carry  = 1'b0;
      unique case (op)
         OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
         OP_SUB: begin
            result = a - b;
            carry  = (a < b);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOT: result = ~b;
         OP_MOV, OP_LDI: result = b;
         default: result = b;
      endcase
   end

endmodule

// File: rtl/reg_alu_sequencer.sv
// Multi-cycle rd <= rd OP rs execute stage sitting on the register
// file: two registered reads, one ALU cycle, one write-back cycle.
module reg_alu_sequencer
   import reg_alu_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int SEL_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [SEL_WIDTH-1:0]  rd,
   input  logic [SEL_WIDTH-1:0]  rs,
   input  logic [DATA_WIDTH-1:0] imm,
   input  logic [DATA_WIDTH-1:0] src,
   output logic [SEL_WIDTH-1:0]  src_bus_selector,
   output logic [SEL_WIDTH-1:0]  dest_bus_selector,
   output logic                  dest_we,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  busy,
   output logic                  done,
   output logic                  flag_z,
   output logic                  flag_c,
   output logic                  flag_n
);

   state_e                state_q, state_d;
   op_e                   op_q, op_d;
   logic [SEL_WIDTH-1:0]  rd_q, rd_d, rs_q, rs_d;
   logic [SEL_WIDTH-1:0]  src_sel_q, src_sel_d;
   logic [SEL_WIDTH-1:0]  dest_sel_q, dest_sel_d;
   logic [DATA_WIDTH-1:0] opa_q, opa_d, data_q, data_d;
   logic [DATA_WIDTH-1:0] alu_res, wb_val;
   logic                  we_q, we_d, busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  z_q, z_d, c_q, c_d, n_q, n_d;
   logic                  alu_c, wb_c, accept;

   // opB is consumed straight off the registered read port in EXEC
   alu_core #(.W(DATA_WIDTH)) u_alu (
      .op     (op_q),
      .a      (opa_q),
      .b      (src),
      .result (alu_res),
      .carry  (alu_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) begin
            state_d = (op_e'(op) == OP_LDI) ? ST_WB : ST_RD_A;
         end
         ST_RD_A: state_d = ST_RD_B;
         ST_RD_B: state_d = ST_EXEC;
         ST_EXEC: state_d = ST_WB;
         ST_WB:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are computed for the state being entered, then registered
   always_comb begin
      accept    = (state_q == ST_IDLE) && start;
      op_d      = op_q;
      rd_d      = rd_q;
      rs_d      = rs_q;
      opa_d     = opa_q;
      src_sel_d = src_sel_q;
      z_d       = z_q;
      c_d       = c_q;
      n_d       = n_q;
      if (accept) begin
         op_d = op_e'(op);
         rd_d = rd;
         rs_d = rs;
      end
      if (state_q == ST_RD_B) opa_d = src;
      if (state_d == ST_RD_A) src_sel_d = rd_d;
      if (state_d == ST_RD_B) src_sel_d = rs_q;
      wb_val     = accept ? imm : alu_res;
      wb_c       = accept ? 1'b0 : alu_c;
      we_d       = (state_d == ST_WB);
      done_d     = we_d;
      busy_d     = (state_d != ST_IDLE);
      dest_sel_d = we_d ? rd_d : SEL_WIDTH'(R0_SELECTOR);
      data_d     = we_d ? wb_val : '0;
      if (we_d) begin
         z_d = (wb_val == '0);
         c_d = wb_c;
         n_d = wb_val[DATA_WIDTH-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q       <= OP_MOV;
         rd_q       <= '0;
         rs_q       <= '0;
         opa_q      <= '0;
         src_sel_q  <= SEL_WIDTH'(R0_SELECTOR);
         dest_sel_q <= SEL_WIDTH'(R0_SELECTOR);
         data_q     <= '0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         z_q        <= 1'b0;
         c_q        <= 1'b0;
         n_q        <= 1'b0;
      end else begin
         op_q       <= op_d;
         rd_q       <= rd_d;
         rs_q       <= rs_d;
         opa_q      <= opa_d;
         src_sel_q  <= src_sel_d;
         dest_sel_q <= dest_sel_d;
         data_q     <= data_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         z_q        <= z_d;
         c_q        <= c_d;
         n_q        <= n_d;
      end
   end

   assign src_bus_selector  = src_sel_q;
   assign dest_bus_selector = dest_sel_q;
   assign dest_we           = we_q;
   assign data              = data_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign flag_z            = z_q;
   assign flag_c            = c_q;
   assign flag_n            = n_q;

endmodule
